pi_ctl_slew: RTL and testbench

Parametrised phase-interpolator control sequencer for the Nout-channel PI bank. It slews each channel's PI code toward a loaded target in bounded steps, with a programmable settle gap between updates, so the PI never sees a large code jump. It drives ctl_pi/ctl_valid into the analog core and replaces direct register writes of the PI codes. It generalises to any channel count and code width, and adds modular shortest-path wrap, per-channel masking and mid-ramp retargeting.

---
 rtl/pi_ctl_slew.sv | 137 +++++++++++++
 tb/tb_pi_ctl_slew.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_ctl_slew.sv
// Phase-interpolator code sequencer: slews each channel's PI code toward its
// loaded target in clamped steps, spaced by a programmable settle gap.
module pi_ctl_slew #(
  parameter int Nout  = 4,
  parameter int Npi   = 9,
  parameter int Nstep = 4,
  parameter int Nhold = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [Nout-1:0][Npi-1:0]  target,
  input  logic                      target_load,
  input  logic [Nout-1:0]           ch_mask,
  input  logic [Nstep-1:0]          max_step,
  input  logic [Nhold-1:0]          hold_cycles,
  input  logic                      wrap_en,
  output logic [Nout-1:0][Npi-1:0]  ctl_pi,
  output logic                      ctl_valid,
  output logic                      busy,
  output logic                      done
);

  localparam int MW = (Npi > Nstep) ? Npi : Nstep;

  typedef enum logic [1:0] {IDLE, STEP, HOLD} state_t;

  state_t                    state, state_next;
  logic [Nhold-1:0]          hold_cnt, hold_next;
  logic [Nout-1:0][Npi-1:0]  tgt;
  logic [Nout-1:0][Npi-1:0]  code_next;
  logic [Nout-1:0][Npi-1:0]  diff;
  logic [Nout-1:0][Npi-1:0]  mag;
  logic [Nout-1:0][Npi-1:0]  sval;
  logic [Nout-1:0]           neg;
  logic [MW-1:0]             step_eff;
  logic                      changed;
  logic                      arrived;
  logic                      load;

  assign load = target_load & en;

  // Per-channel step: signed distance to target, clamped to the step size.
  // In wrap mode the exact half-circle distance is taken as positive.
  always_comb begin
    step_eff = (max_step == '0) ? MW'(1) : MW'(max_step);
    changed  = 1'b0;
    arrived  = 1'b1;
    for (int i = 0; i < Nout; i++) begin
      diff[i] = tgt[i] - ctl_pi[i];
      if (wrap_en) begin
        neg[i] = diff[i][Npi-1] & (|diff[i][Npi-2:0]);
        mag[i] = neg[i] ? ('0 - diff[i]) : diff[i];
      end else begin
        neg[i] = (tgt[i] < ctl_pi[i]);
        mag[i] = neg[i] ? (ctl_pi[i] - tgt[i]) : (tgt[i] - ctl_pi[i]);
      end
      sval[i] = (MW'(mag[i]) > step_eff) ? step_eff[Npi-1:0] : mag[i];
      if (ch_mask[i])
        code_next[i] = ctl_pi[i];
      else if (neg[i])
        code_next[i] = ctl_pi[i] - sval[i];
      else
        code_next[i] = ctl_pi[i] + sval[i];
      if (code_next[i] != ctl_pi[i])
        changed = 1'b1;
      if (!ch_mask[i] && (code_next[i] != tgt[i]))
        arrived = 1'b0;
    end
  end

  // A load landing on the final step supersedes arrival, so the ramp continues.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    if (!en) begin
      state_next = IDLE;
      hold_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (load)
            state_next = STEP;
        end
        STEP: begin
          if (arrived && !load) begin
            state_next = IDLE;
            hold_next  = '0;
          end else if (hold_cycles == '0) begin
            state_next = STEP;
          end else begin
            state_next = HOLD;
            hold_next  = hold_cycles;
          end
        end
        HOLD: begin
          if (hold_cnt <= Nhold'(1)) begin
            state_next = STEP;
            hold_next  = '0;
          end else begin
            hold_next = hold_cnt - Nhold'(1);
          end
        end
        default: begin
          state_next = IDLE;
          hold_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      tgt       <= '0;
      ctl_pi    <= '0;
      ctl_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_next;
      busy      <= (state_next != IDLE);
      ctl_valid <= 1'b0;
      done      <= 1'b0;
      if (load)
        tgt <= target;
      if (en && (state == STEP)) begin
        ctl_pi    <= code_next;
        ctl_valid <= changed;
        done      <= arrived & ~load;
      end
    end
  end

endmodule

// File: tb/tb_pi_ctl_slew.sv
// Directed bench for pi_ctl_slew: hand-computed ramps covering wrap, tie,
// clamp, retarget, masking, abort and reset behaviour.
module tb_pi_ctl_slew;

  logic             clk;
  logic             rst;
  logic             en;
  logic [3:0][8:0]  target;
  logic             target_load;
  logic [3:0]       ch_mask;
  logic [3:0]       max_step;
  logic [7:0]       hold_cycles;
  logic             wrap_en;
  logic [3:0][8:0]  ctl_pi;
  logic             ctl_valid;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_pass   = 0;

  int lin_code[8]  = '{8, 8, 8, 16, 16, 16, 20, 20};
  int lin_valid[8] = '{1, 0, 0, 1, 0, 0, 1, 0};
  int lin_done[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
  int rt_exp[4]    = '{32, 24, 16, 10};
  int rt_seq[4];

  pi_ctl_slew #(.Nout(4), .Npi(9), .Nstep(4), .Nhold(8)) dut (
    .clk(clk), .rst(rst), .en(en), .target(target), .target_load(target_load),
    .ch_mask(ch_mask), .max_step(max_step), .hold_cycles(hold_cycles),
    .wrap_en(wrap_en), .ctl_pi(ctl_pi), .ctl_valid(ctl_valid), .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0][8:0] mk(input int c3, input int c2, input int c1, input int c0);
    return {9'(c3), 9'(c2), 9'(c1), 9'(c0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drives a new configuration and pulses target_load across one edge.
  task automatic applyStimulus(input logic [3:0][8:0] t, input logic [3:0] ms,
                               input logic [7:0] hc, input logic w);
    target      = t;
    max_step    = ms;
    hold_cycles = hc;
    wrap_en     = w;
    target_load = 1'b1;
    tick();
    target_load = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget, output int pulses);
    bit seen;
    pulses = 0;
    seen   = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (ctl_valid) pulses++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_done_seen"}, 32'(seen), 1);
  endtask

  initial begin
    int p;
    int prev;
    int bad;
    int dones;
    int guard;

    rst = 1'b1; en = 1'b0; target = '0; target_load = 1'b0; ch_mask = '0;
    max_step = '0; hold_cycles = '0; wrap_en = 1'b0;
    tick();
    tick();
    checkOutput("rst_code", 32'(ctl_pi[0]) | 32'(ctl_pi[1]) | 32'(ctl_pi[2]) | 32'(ctl_pi[3]), 0);
    checkOutput("rst_valid", 32'(ctl_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);

    rst = 1'b0; en = 1'b1;
    p = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ctl_valid || busy || done || (ctl_pi != '0)) p++;
    end
    checkOutput("idle_quiet", 32'(p), 0);

    // Targets already equal to codes: done without an update.
    applyStimulus(mk(0, 0, 0, 0), 8, 2, 0);
    tick();
    checkOutput("eq_done", 32'(done), 1);
    checkOutput("eq_valid", 32'(ctl_valid), 0);
    tick();
    checkOutput("eq_busy", 32'(busy), 0);

    // Linear ramp 0 -> 20, step 8, hold 2.
    applyStimulus(mk(0, 0, 0, 20), 8, 2, 0);
    checkOutput("lin_busy_start", 32'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("lin_code%0d", i), 32'(ctl_pi[0]), 32'(lin_code[i]));
      checkOutput($sformatf("lin_valid%0d", i), 32'(ctl_valid), 32'(lin_valid[i]));
      checkOutput($sformatf("lin_done%0d", i), 32'(done), 32'(lin_done[i]));
    end
    checkOutput("lin_busy_end", 32'(busy), 0);

    // Preset ch1 to 500 via the short way round (0 -> -12).
    applyStimulus(mk(0, 0, 500, 20), 15, 0, 1);
    tick();
    checkOutput("pre_ch1", 32'(ctl_pi[1]), 500);
    checkOutput("pre_done", 32'(done), 1);
    checkOutput("pre_ch0", 32'(ctl_pi[0]), 20);

    // Wrap forward 500 -> 508 -> 4.
    applyStimulus(mk(0, 0, 4, 20), 8, 0, 1);
    tick();
    checkOutput("wrap_508", 32'(ctl_pi[1]), 508);
    checkOutput("wrap_v1", 32'(ctl_valid), 1);
    checkOutput("wrap_d1", 32'(done), 0);
    tick();
    checkOutput("wrap_4", 32'(ctl_pi[1]), 4);
    checkOutput("wrap_d2", 32'(done), 1);

    // Back to 500 by wrapping backward: 4 -> 501 -> 500.
    applyStimulus(mk(0, 0, 500, 20), 15, 0, 1);
    waitDone("back", 20, p);
    checkOutput("back_pulses", 32'(p), 2);
    checkOutput("back_ch1", 32'(ctl_pi[1]), 500);

    // Linear mode never wraps: 500 down to 4 in 62 steps of 8.
    applyStimulus(mk(0, 0, 4, 20), 8, 0, 0);
    waitDone("lin_desc", 100, p);
    checkOutput("lin_desc_pulses", 32'(p), 62);
    checkOutput("lin_desc_ch1", 32'(ctl_pi[1]), 4);

    // Half-circle tie goes up; max_step 0 behaves as 1.
    applyStimulus(mk(0, 256, 4, 20), 0, 0, 1);
    prev = 0; bad = 0; p = 0; guard = 0;
    while (!done && guard < 400) begin
      tick();
      guard++;
      if (ctl_valid) begin
        p++;
        if (int'(ctl_pi[2]) != prev + 1) bad++;
        prev = int'(ctl_pi[2]);
      end
    end
    checkOutput("tie_done_seen", 32'(done), 1);
    checkOutput("tie_pulses", 32'(p), 256);
    checkOutput("tie_bad_steps", 32'(bad), 0);
    checkOutput("tie_ch2", 32'(ctl_pi[2]), 256);

    applyStimulus(mk(0, 256, 4, 0), 15, 0, 0);
    waitDone("zero", 20, p);
    checkOutput("zero_pulses", 32'(p), 2);
    checkOutput("zero_ch0", 32'(ctl_pi[0]), 0);

    // Retarget mid-ramp and freeze ch3.
    applyStimulus(mk(50, 256, 4, 100), 8, 1, 0);
    guard = 0;
    while (!(ctl_valid && ctl_pi[0] == 9'd40) && guard < 60) begin
      tick();
      guard++;
    end
    checkOutput("rt_reach40", 32'(ctl_valid && ctl_pi[0] == 9'd40), 1);
    checkOutput("rt_ch3_40", 32'(ctl_pi[3]), 40);
    ch_mask = 4'b1000;
    applyStimulus(mk(50, 256, 4, 10), 8, 1, 0);
    p = 0; dones = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (ctl_valid) begin
        if (p < 4) rt_seq[p] = int'(ctl_pi[0]);
        p++;
      end
      if (done) dones++;
    end
    checkOutput("rt_pulses", 32'(p), 4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("rt_seq%0d", i), 32'(rt_seq[i]), 32'(rt_exp[i]));
    checkOutput("rt_dones", 32'(dones), 1);
    checkOutput("rt_ch3_frozen", 32'(ctl_pi[3]), 40);
    checkOutput("rt_busy", 32'(busy), 0);

    // Load coinciding with the final step: new target wins, no done.
    ch_mask = '0;
    applyStimulus(mk(40, 256, 4, 15), 8, 0, 0);
    target = mk(40, 256, 4, 19);
    target_load = 1'b1;
    tick();
    target_load = 1'b0;
    checkOutput("late_ch0_15", 32'(ctl_pi[0]), 15);
    checkOutput("late_valid", 32'(ctl_valid), 1);
    checkOutput("late_no_done", 32'(done), 0);
    tick();
    checkOutput("late_ch0_19", 32'(ctl_pi[0]), 19);
    checkOutput("late_done", 32'(done), 1);

    // Abort with en low mid-ramp.
    applyStimulus(mk(40, 256, 4, 100), 7, 0, 0);
    tick();
    checkOutput("ab_ch0_26", 32'(ctl_pi[0]), 26);
    en = 1'b0;
    tick();
    checkOutput("ab_hold", 32'(ctl_pi[0]), 26);
    checkOutput("ab_busy", 32'(busy), 0);
    checkOutput("ab_valid", 32'(ctl_valid), 0);
    checkOutput("ab_done", 32'(done), 0);
    target = mk(40, 256, 4, 200);
    target_load = 1'b1;
    tick();
    target_load = 1'b0;
    en = 1'b1;
    tick();
    tick();
    checkOutput("ab_ignored_busy", 32'(busy), 0);
    checkOutput("ab_ignored_code", 32'(ctl_pi[0]), 26);

    // Reset mid-ramp.
    applyStimulus(mk(40, 256, 4, 100), 7, 0, 0);
    tick();
    checkOutput("rr_ch0_33", 32'(ctl_pi[0]), 33);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rr_ch0", 32'(ctl_pi[0]), 0);
    checkOutput("rr_ch1", 32'(ctl_pi[1]), 0);
    checkOutput("rr_ch2", 32'(ctl_pi[2]), 0);
    checkOutput("rr_ch3", 32'(ctl_pi[3]), 0);
    checkOutput("rr_valid", 32'(ctl_valid), 0);
    checkOutput("rr_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
